// File: rtl/ibex_rf_wb_queue.sv
// ibex_rf_wb_queue: write-back queue in front of the latch register file write port.
// Merges the EX and LSU write-back streams into one RF write per cycle, buffers
// same-cycle collisions and hides the latch write latency from ID.
// Optional feature macro IBEX_WBQ_FWD_EN: when defined, pending and retiring data
// is forwarded to the read ports. When undefined, reads are passed through and
// raw_hazard_o flags reads that would otherwise see stale data.
module ibex_rf_wb_queue #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2
) (
    input  logic                 clk_int,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 we_a_o,
    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 raw_hazard_o,
    output logic                 empty_o
);
    localparam int unsigned AddrW = RV32E ? 4 : 5;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    // Entry 0 is the head (oldest); higher indices are younger.
    logic [4:0]           q_addr   [Depth];
    logic [DataWidth-1:0] q_data   [Depth];
    logic [4:0]           q_addr_n [Depth];
    logic [DataWidth-1:0] q_data_n [Depth];

    logic [CntW-1:0] count, count_n, count_pp, ex_slot;
    logic [CntW:0]   free;
    logic            pop, lsu_nz, ex_nz, lsu_push, ex_push;

    logic            retire_valid;
    logic [4:0]      retire_addr;
`ifdef IBEX_WBQ_FWD_EN
    logic [DataWidth-1:0] retire_data;
`endif

    // The head is written to the RF every cycle the queue is non-empty.
    assign pop      = (count != '0);
    assign count_pp = count - CntW'(pop);
    assign free     = (CntW+1)'(Depth) - {1'b0, count} + (CntW+1)'(pop);

    // Writes to x0 are acknowledged but dropped.
    assign lsu_nz = |lsu_waddr_i[AddrW-1:0];
    assign ex_nz  = |ex_waddr_i[AddrW-1:0];

    // LSU belongs to the older instruction, so it claims a free slot first.
    assign lsu_ready_o = (free >= (CntW+1)'(1));
    assign ex_ready_o  = (free >= (CntW+1)'(1) + (CntW+1)'(lsu_valid_i & lsu_nz));
    assign lsu_push    = lsu_valid_i & lsu_ready_o & lsu_nz;
    assign ex_push     = ex_valid_i & ex_ready_o & ex_nz;

    // Pushes land behind the post-pop tail, LSU before EX.
    assign ex_slot = count_pp + CntW'(lsu_push);
    assign count_n = count_pp + CntW'(lsu_push) + CntW'(ex_push);

    // Next queue contents: shift out the head on pop, then insert new entries.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            q_addr_n[i] = q_addr[i];
            q_data_n[i] = q_data[i];
        end
        if (pop) begin
            for (int i = 0; i < Depth - 1; i++) begin
                q_addr_n[i] = q_addr[i+1];
                q_data_n[i] = q_data[i+1];
            end
        end
        for (int i = 0; i < Depth; i++) begin
            if (lsu_push && (CntW'(i) == count_pp)) begin
                q_addr_n[i] = lsu_waddr_i;
                q_data_n[i] = lsu_wdata_i;
            end
            if (ex_push && (CntW'(i) == ex_slot)) begin
                q_addr_n[i] = ex_waddr_i;
                q_data_n[i] = ex_wdata_i;
            end
        end
    end

    // Occupancy and retire-slot valid; reset drops every pending write at once.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            count        <= '0;
            retire_valid <= 1'b0;
        end else begin
            count        <= count_n;
            retire_valid <= pop;
        end
    end

    // Payload storage; contents only matter while covered by count/retire_valid.
    always_ff @(posedge clk_int) begin
        for (int i = 0; i < Depth; i++) begin
            q_addr[i] <= q_addr_n[i];
            q_data[i] <= q_data_n[i];
        end
        if (pop) begin
            retire_addr <= q_addr[0];
`ifdef IBEX_WBQ_FWD_EN
            retire_data <= q_data[0];
`endif
        end
    end

    assign we_a_o    = pop;
    assign waddr_a_o = pop ? q_addr[0] : '0;
    assign wdata_a_o = pop ? q_data[0] : '0;
    assign empty_o   = ~pop & ~retire_valid;

`ifdef IBEX_WBQ_FWD_EN
    logic [DataWidth-1:0] fwd_a, fwd_b;

    // Forward read data: youngest queue entry beats retire slot beats the RF.
    always_comb begin
        fwd_a = rf_rdata_a_i;
        fwd_b = rf_rdata_b_i;
        if (retire_valid && (retire_addr[AddrW-1:0] == raddr_a_i[AddrW-1:0])) fwd_a = retire_data;
        if (retire_valid && (retire_addr[AddrW-1:0] == raddr_b_i[AddrW-1:0])) fwd_b = retire_data;
        for (int i = 0; i < Depth; i++) begin
            if ((CntW'(i) < count) && (q_addr[i][AddrW-1:0] == raddr_a_i[AddrW-1:0])) fwd_a = q_data[i];
            if ((CntW'(i) < count) && (q_addr[i][AddrW-1:0] == raddr_b_i[AddrW-1:0])) fwd_b = q_data[i];
        end
        if (raddr_a_i[AddrW-1:0] == '0) fwd_a = rf_rdata_a_i;
        if (raddr_b_i[AddrW-1:0] == '0) fwd_b = rf_rdata_b_i;
    end

    assign rdata_a_o    = fwd_a;
    assign rdata_b_o    = fwd_b;
    assign raw_hazard_o = 1'b0;
`else
    logic hit_a, hit_b;

    // Flag reads of registers with a write still pending or retiring.
    always_comb begin
        hit_a = retire_valid && (retire_addr[AddrW-1:0] == raddr_a_i[AddrW-1:0]);
        hit_b = retire_valid && (retire_addr[AddrW-1:0] == raddr_b_i[AddrW-1:0]);
        for (int i = 0; i < Depth; i++) begin
            if ((CntW'(i) < count) && (q_addr[i][AddrW-1:0] == raddr_a_i[AddrW-1:0])) hit_a = 1'b1;
            if ((CntW'(i) < count) && (q_addr[i][AddrW-1:0] == raddr_b_i[AddrW-1:0])) hit_b = 1'b1;
        end
    end

    assign rdata_a_o    = rf_rdata_a_i;
    assign rdata_b_o    = rf_rdata_b_i;
    assign raw_hazard_o = ((|raddr_a_i[AddrW-1:0]) & hit_a) | ((|raddr_b_i[AddrW-1:0]) & hit_b);
`endif

endmodule

// File: tb/tb_ibex_rf_wb_queue.sv
// Bench for ibex_rf_wb_queue: RF writes are checked against a scoreboard of expected
// writes; scenario tasks check ready, forwarding, hazard and empty behaviour inline.
module tb_ibex_rf_wb_queue;
    localparam int DW = 32;
    localparam int D  = 2;

    logic          clk_int = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          ex_valid_i = 1'b0, lsu_valid_i = 1'b0;
    logic          ex_ready_o, lsu_ready_o;
    logic [4:0]    ex_waddr_i = '0, lsu_waddr_i = '0;
    logic [DW-1:0] ex_wdata_i = '0, lsu_wdata_i = '0;
    logic          we_a_o;
    logic [4:0]    waddr_a_o;
    logic [DW-1:0] wdata_a_o;
    logic [4:0]    raddr_a_i = '0, raddr_b_i = '0;
    logic [DW-1:0] rf_rdata_a_i = '0, rf_rdata_b_i = '0;
    logic [DW-1:0] rdata_a_o, rdata_b_o;
    logic          raw_hazard_o, empty_o;

    ibex_rf_wb_queue #(.RV32E(1'b0), .DataWidth(DW), .Depth(D)) dut (
        .clk_int(clk_int), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o), .raw_hazard_o(raw_hazard_o), .empty_o(empty_o)
    );

    always #5 clk_int = ~clk_int;

    typedef struct packed {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  mcount   = 0;

    // Every RF write must match the oldest expected write.
    always @(negedge clk_int) begin
        if (rst_ni && we_a_o) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required no write", waddr_a_o, wdata_a_o);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if ({waddr_a_o, wdata_a_o} !== {e.a, e.d}) begin
                    failures++;
                    $display("FAIL rf_write actual addr=%0d data=%h required addr=%0d data=%h",
                             waddr_a_o, wdata_a_o, e.a, e.d);
                end
            end
        end
    end

    task automatic expect_wr(input logic [4:0] a, input logic [DW-1:0] d);
        sb.push_back(wr_t'{a, d});
    endtask

    task automatic step();
        @(posedge clk_int);
        #1;
    endtask

    task automatic idle();
        ex_valid_i  = 1'b0;
        lsu_valid_i = 1'b0;
    endtask

    task automatic drive_ex(input logic [4:0] a, input logic [DW-1:0] d);
        ex_valid_i = 1'b1; ex_waddr_i = a; ex_wdata_i = d;
    endtask

    task automatic drive_lsu(input logic [4:0] a, input logic [DW-1:0] d);
        lsu_valid_i = 1'b1; lsu_waddr_i = a; lsu_wdata_i = d;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) step();
        rst_ni = 1'b1;
        @(negedge clk_int);
        checks++; if (we_a_o !== 1'b0) begin failures++; $display("FAIL reset_we actual=%0b required=0", we_a_o); end
        checks++; if (waddr_a_o !== 5'd0) begin failures++; $display("FAIL reset_waddr actual=%0d required=0", waddr_a_o); end
        checks++; if (wdata_a_o !== '0) begin failures++; $display("FAIL reset_wdata actual=%h required=0", wdata_a_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty actual=%0b required=1", empty_o); end
        checks++; if (raw_hazard_o !== 1'b0) begin failures++; $display("FAIL reset_hazard actual=%0b required=0", raw_hazard_o); end
        checks++; if ({lsu_ready_o, ex_ready_o} !== 2'b11) begin failures++; $display("FAIL reset_ready actual=%b required=11", {lsu_ready_o, ex_ready_o}); end
        step();
    endtask

    task automatic wait_empty(input string name);
        for (int k = 0; k < 4 && !empty_o; k++) step();
        @(negedge clk_int);
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL %s actual=%0b required=1", name, empty_o); end
        step();
    endtask

    task automatic test_ex_only();
        drive_ex(5'd5, 32'hDEAD_BEEF);
        @(negedge clk_int);
        checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL ex_only_ready actual=%0b required=1", ex_ready_o); end
        expect_wr(5'd5, 32'hDEAD_BEEF);
        step(); idle();
        @(negedge clk_int);
        checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL ex_only_write actual we=%0b addr=%0d data=%h required we=1 addr=5 data=deadbeef", we_a_o, waddr_a_o, wdata_a_o);
        end
        step();
        wait_empty("ex_only_empty");
    endtask

    task automatic test_collision();
        drive_lsu(5'd3, 32'h11); drive_ex(5'd4, 32'h22);
        @(negedge clk_int);
        checks++; if ({lsu_ready_o, ex_ready_o} !== 2'b11) begin failures++; $display("FAIL collision_ready actual=%b required=11", {lsu_ready_o, ex_ready_o}); end
        expect_wr(5'd3, 32'h11); expect_wr(5'd4, 32'h22);
        step(); idle();
        @(negedge clk_int);
        checks++; if (waddr_a_o !== 5'd3) begin failures++; $display("FAIL collision_first actual=%0d required=3", waddr_a_o); end
        step();
        @(negedge clk_int);
        checks++; if (waddr_a_o !== 5'd4) begin failures++; $display("FAIL collision_second actual=%0d required=4", waddr_a_o); end
        step();
        wait_empty("collision_empty");
    endtask

    task automatic test_full();
        drive_lsu(5'd10, 32'hA1); drive_ex(5'd11, 32'hA2);
        expect_wr(5'd10, 32'hA1); expect_wr(5'd11, 32'hA2);
        step();
        drive_lsu(5'd12, 32'hB1); drive_ex(5'd13, 32'hB2);
        @(negedge clk_int);
        checks++; if ({lsu_ready_o, ex_ready_o} !== 2'b10) begin failures++; $display("FAIL full_ready actual=%b required=10", {lsu_ready_o, ex_ready_o}); end
        expect_wr(5'd12, 32'hB1);
        step();
        lsu_valid_i = 1'b0;
        @(negedge clk_int);
        checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL full_ex_retry actual=%0b required=1", ex_ready_o); end
        expect_wr(5'd13, 32'hB2);
        step();
        // Full again, but an LSU write to x0 does not consume the last slot.
        drive_lsu(5'd0, 32'hC1); drive_ex(5'd14, 32'hC2);
        @(negedge clk_int);
        checks++; if ({lsu_ready_o, ex_ready_o} !== 2'b11) begin failures++; $display("FAIL full_lsu_x0_ready actual=%b required=11", {lsu_ready_o, ex_ready_o}); end
        expect_wr(5'd14, 32'hC2);
        step(); idle();
        wait_empty("full_empty");
    endtask

    task automatic check_read(input string name, input logic [DW-1:0] fwd_val, input logic hazard);
        @(negedge clk_int);
        checks++; if (rdata_b_o !== rf_rdata_b_i) begin failures++; $display("FAIL %s_b_x0 actual=%h required=%h", name, rdata_b_o, rf_rdata_b_i); end
`ifdef IBEX_WBQ_FWD_EN
        checks++; if (rdata_a_o !== fwd_val) begin failures++; $display("FAIL %s_a actual=%h required=%h", name, rdata_a_o, fwd_val); end
        checks++; if (raw_hazard_o !== 1'b0) begin failures++; $display("FAIL %s_hazard actual=%0b required=0", name, raw_hazard_o); end
`else
        checks++; if (rdata_a_o !== rf_rdata_a_i) begin failures++; $display("FAIL %s_a actual=%h required=%h", name, rdata_a_o, rf_rdata_a_i); end
        checks++; if (raw_hazard_o !== hazard) begin failures++; $display("FAIL %s_hazard actual=%0b required=%0b", name, raw_hazard_o, hazard); end
        if (fwd_val === 'x) $display("unreachable");
`endif
        step();
    endtask

    task automatic test_forward();
        rf_rdata_a_i = '0; rf_rdata_b_i = 32'h1234; raddr_a_i = 5'd7; raddr_b_i = 5'd0;
        drive_ex(5'd7, 32'h55); expect_wr(5'd7, 32'h55);
        step(); idle();
        check_read("fwd_queued", 32'h55, 1'b1);
        check_read("fwd_retire", 32'h55, 1'b1);
        check_read("fwd_done", 32'h0, 1'b0);
        raddr_a_i = 5'd9;
        drive_lsu(5'd9, 32'hA); drive_ex(5'd9, 32'hB);
        expect_wr(5'd9, 32'hA); expect_wr(5'd9, 32'hB);
        step(); idle();
        check_read("fwd_young_q", 32'hB, 1'b1);
        check_read("fwd_young_qr", 32'hB, 1'b1);
        check_read("fwd_young_r", 32'hB, 1'b1);
        check_read("fwd_young_done", 32'h0, 1'b0);
        raddr_a_i = '0;
        wait_empty("fwd_empty");
    endtask

    task automatic test_x0();
        drive_ex(5'd0, 32'hFFFF);
        @(negedge clk_int);
        checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL x0_ready actual=%0b required=1", ex_ready_o); end
        step(); idle();
        @(negedge clk_int);
        checks++; if ({we_a_o, empty_o} !== 2'b01) begin failures++; $display("FAIL x0_no_write actual we=%0b empty=%0b required we=0 empty=1", we_a_o, empty_o); end
        step();
    endtask

    task automatic test_reset_mid();
        drive_lsu(5'd3, 32'h33); drive_ex(5'd4, 32'h44);
        step(); idle();
        rst_ni = 1'b0;
        #1;
        checks++; if ({we_a_o, empty_o} !== 2'b01) begin failures++; $display("FAIL reset_mid actual we=%0b empty=%0b required we=0 empty=1", we_a_o, empty_o); end
        repeat (3) step();
        rst_ni = 1'b1;
        repeat (4) step();
        @(negedge clk_int);
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_mid_after actual=%0b required=1", empty_o); end
        step();
        mcount = 0;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            int  free;
            logic lv, ev, lnz, enz, elr, eer;
            logic [4:0] la, ea;
            logic [DW-1:0] ld, ed;
            lv = 1'($urandom_range(0, 1)); ev = 1'($urandom_range(0, 1));
            la = 5'($urandom_range(0, 31)); ea = 5'($urandom_range(0, 31));
            ld = $urandom; ed = $urandom;
            lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
            ex_valid_i  = ev; ex_waddr_i  = ea; ex_wdata_i  = ed;
            free = D - mcount + (mcount != 0 ? 1 : 0);
            lnz = (la != 0); enz = (ea != 0);
            elr = (free >= 1);
            eer = (free >= 1 + ((lv && lnz) ? 1 : 0));
            @(negedge clk_int);
            checks++; if ({lsu_ready_o, ex_ready_o} !== {elr, eer}) begin
                failures++; $display("FAIL b2b_ready cycle=%0d actual=%b required=%b", n, {lsu_ready_o, ex_ready_o}, {elr, eer});
            end
            mcount = mcount - (mcount != 0 ? 1 : 0);
            if (lv && elr && lnz) begin expect_wr(la, ld); mcount++; end
            if (ev && eer && enz) begin expect_wr(ea, ed); mcount++; end
            step();
        end
        idle();
        repeat (5) step();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain actual=%0d pending required=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_ex_only();
        test_collision();
        test_full();
        test_forward();
        test_x0();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
